audio_pwm_out: RTL and testbench

Downstream output stage for the audio chain: accepts filtered PCM samples from `noise_filter` over a valid/ready handshake. Buffers them in a small FIFO and plays one sample per PWM period as a single-bit pulse-width-modulated output for an external RC low-pass/speaker driver. Absorbs jitter between the filter's sample production and the fixed PWM playback rate, and flags underruns.

---
 rtl/audio_pkg.sv | 14 +
 rtl/audio_pwm_out_if.sv | 25 ++
 rtl/audio_sample_fifo.sv | 64 ++++++
 rtl/audio_pwm_out.sv | 132 +++++++++++++
 tb/tb_audio_pwm_out.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared constants and types for the audio output chain.
// No logic; imported by the PWM output stage and its sample FIFO.
package audio_pkg;

    localparam int BIT_DEPTH_DEFAULT  = 8;
    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int UNDERRUN_CNT_W     = 16;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } pwm_state_t;

endpackage

// File: rtl/audio_pwm_out_if.sv
// Sample handshake from the noise filter into the PWM output stage.
// Transfer happens on a clock where sample_valid && sample_ready.
interface audio_pwm_out_if
    import audio_pkg::*;
#(
    parameter int bit_depth = BIT_DEPTH_DEFAULT
) ();

    logic [bit_depth-1:0] sample_in;
    logic                 sample_valid;
    logic                 sample_ready;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/audio_sample_fifo.sv
// Sample FIFO: registered push, head visible combinationally, pop/push same cycle keeps level.
// Pushes while full and pops while empty are ignored; level is tracked explicitly.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int bit_depth  = BIT_DEPTH_DEFAULT,
    parameter int fifo_depth = FIFO_DEPTH_DEFAULT,
    localparam int LVL_W     = $clog2(fifo_depth) + 1,
    localparam int PTR_W     = (fifo_depth > 1) ? $clog2(fifo_depth) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_push,
    input  logic [bit_depth-1:0] i_push_dat,
    input  logic                 i_pop,
    output logic [bit_depth-1:0] o_pop_dat,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [LVL_W-1:0]     o_level
);

    logic [bit_depth-1:0] r_mem [fifo_depth];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic                 w_push;
    logic                 w_pop;

    assign o_full    = (r_level == LVL_W'(fifo_depth));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_pop_dat = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Depth is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

endmodule

// File: rtl/audio_pwm_out.sv
// PWM audio output: buffers samples, plays one per 2^bit_depth-clock period, pwm_out lags cnt by 1 clock.
// sample_ready drops only when the FIFO is full; AUDIO_PWM_UNDERRUN_CNT_EN adds a saturating underrun_count.
module audio_pwm_out
    import audio_pkg::*;
#(
    parameter int bit_depth  = BIT_DEPTH_DEFAULT,
    parameter int fifo_depth = FIFO_DEPTH_DEFAULT,
    localparam int LVL_W     = $clog2(fifo_depth) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    audio_pwm_out_if.slave            s_if,
    output logic                      pwm_out,
    output logic [LVL_W-1:0]          fifo_level,
    output logic                      underrun
`ifdef AUDIO_PWM_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0] underrun_count
`endif
);

    pwm_state_t           r_state;
    pwm_state_t           w_state_nxt;
    logic [bit_depth-1:0] r_cnt;
    logic [bit_depth-1:0] r_duty;
    logic                 r_pwm;
    logic                 r_underrun;

    logic [bit_depth-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [LVL_W-1:0]     w_level;
    logic                 w_prime_ok;
    logic                 w_cnt_max;
    logic                 w_pop;
    logic                 w_cnt_en;
    logic                 w_underrun_hit;

    audio_sample_fifo #(
        .bit_depth  (bit_depth),
        .fifo_depth (fifo_depth)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (s_if.sample_valid),
        .i_push_dat (s_if.sample_in),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (w_level)
    );

    assign s_if.sample_ready = !w_full;
    assign fifo_level        = w_level;
    assign pwm_out           = r_pwm;
    assign underrun          = r_underrun;

    assign w_prime_ok = (w_level >= LVL_W'(fifo_depth / 2));
    assign w_cnt_max  = (r_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PRIME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PRIME is left once half the FIFO is buffered; RUN is only left by reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PRIME:   if (w_prime_ok) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = PRIME;
        endcase
    end

    always_comb begin
        w_pop          = 1'b0;
        w_cnt_en       = 1'b0;
        w_underrun_hit = 1'b0;
        case (r_state)
            PRIME: begin
                w_pop = w_prime_ok;
            end
            RUN: begin
                w_cnt_en = 1'b1;
                if (w_cnt_max) begin
                    w_pop          = !w_empty;
                    w_underrun_hit = w_empty;
                end
            end
            default: begin
                w_pop = 1'b0;
            end
        endcase
    end

    // Duty only changes at a period boundary, so each period plays a single sample cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_duty     <= '0;
            r_pwm      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_en ? r_cnt + bit_depth'(1) : '0;
            r_pwm      <= (r_state == RUN) && (r_cnt < r_duty);
            r_underrun <= w_underrun_hit;
            if (w_pop) begin
                r_duty <= w_head;
            end
        end
    end

`ifdef AUDIO_PWM_UNDERRUN_CNT_EN
    logic [UNDERRUN_CNT_W-1:0] r_underrun_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_underrun_cnt <= '0;
        end else if (w_underrun_hit && (r_underrun_cnt != '1)) begin
            r_underrun_cnt <= r_underrun_cnt + UNDERRUN_CNT_W'(1);
        end
    end

    assign underrun_count = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out at bit_depth 8, fifo_depth 4.
module tb_audio_pwm_out;
    import audio_pkg::*;

    localparam int BD = 8;
    localparam int FD = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pwm_out;
    logic          underrun;
    logic [LW-1:0] fifo_level;
`ifdef AUDIO_PWM_UNDERRUN_CNT_EN
    logic [15:0]   underrun_count;
`endif

    int checks = 0;
    int errors = 0;

    audio_pwm_out_if #(.bit_depth(BD)) bus ();

    audio_pwm_out #(
        .bit_depth  (BD),
        .fifo_depth (FD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_if           (bus),
        .pwm_out        (pwm_out),
        .fifo_level     (fifo_level),
        .underrun       (underrun)
`ifdef AUDIO_PWM_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [BD-1:0] v);
        logic acc;
        bit   done;
        done = 0;
        bus.sample_in    = v;
        bus.sample_valid = 1'b1;
        for (int k = 0; k < 2000 && !done; k++) begin
            acc = bus.sample_ready;
            tick();
            if (acc) done = 1;
        end
        bus.sample_valid = 1'b0;
        checks++;
        if (!done) begin errors++; $display("FAIL push_timeout sample=%0d not accepted within 2000 cycles", v); end
    endtask

    task automatic measure(input int n, output int highs, output int urs, output logic last, output int maxlvl);
        highs = 0; urs = 0; last = 1'b0; maxlvl = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (pwm_out) highs++;
            if (underrun) urs++;
            last = pwm_out;
            if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
        end
    endtask

    task automatic do_reset();
        bus.sample_valid = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL rst_pwm got %b exp 0", pwm_out); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b exp 0", underrun); end
        checks++; if (bus.sample_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.sample_ready); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
`ifdef AUDIO_PWM_UNDERRUN_CNT_EN
        checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL rst_ucount got %0d exp 0", underrun_count); end
`endif
    endtask

    task automatic test_basic();
        int h, u, m; logic l;
        do_reset();
        push(8'd50);
        push(8'd100);
        checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL basic_level2 got %0d exp 2", fifo_level); end
        tick();
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL basic_level_pop got %0d exp 1", fifo_level); end
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL basic_pwm_exit got %b exp 0", pwm_out); end
        measure(256, h, u, l, m);
        checks++; if (h != 50) begin errors++; $display("FAIL basic_p1_highs got %0d exp 50", h); end
        checks++; if (u != 0) begin errors++; $display("FAIL basic_p1_underrun got %0d exp 0", u); end
        measure(256, h, u, l, m);
        checks++; if (h != 100) begin errors++; $display("FAIL basic_p2_highs got %0d exp 100", h); end
        checks++; if (u != 1) begin errors++; $display("FAIL basic_p2_underrun got %0d exp 1", u); end
`ifdef AUDIO_PWM_UNDERRUN_CNT_EN
        checks++; if (underrun_count !== 16'd1) begin errors++; $display("FAIL basic_ucount got %0d exp 1", underrun_count); end
`endif
    endtask

    task automatic test_underrun();
        int h, u, m; logic l;
        for (int p = 0; p < 2; p++) begin
            measure(256, h, u, l, m);
            checks++; if (h != 100) begin errors++; $display("FAIL ur_highs period=%0d got %0d exp 100", p, h); end
            checks++; if (u != 1) begin errors++; $display("FAIL ur_pulses period=%0d got %0d exp 1", p, u); end
`ifdef AUDIO_PWM_UNDERRUN_CNT_EN
            checks++; if (underrun_count !== 16'(p + 2)) begin errors++; $display("FAIL ur_ucount period=%0d got %0d exp %0d", p, underrun_count, p + 2); end
`endif
        end
    endtask

    task automatic test_extremes();
        int h, u, m; logic l;
        do_reset();
        push(8'd0);
        push(8'd255);
        tick();
        measure(256, h, u, l, m);
        checks++; if (h != 0) begin errors++; $display("FAIL ext_zero_highs got %0d exp 0", h); end
        measure(256, h, u, l, m);
        checks++; if (h != 255) begin errors++; $display("FAIL ext_max_highs got %0d exp 255", h); end
        checks++; if (l !== 1'b0) begin errors++; $display("FAIL ext_max_last got %b exp 0", l); end
    endtask

    task automatic test_full_hold();
        int h, u, m, k, first;
        logic l;
        int exp_d [4] = '{30, 40, 50, 60};
        do_reset();
        push(8'd10); push(8'd20); push(8'd30); push(8'd40); push(8'd50);
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level got %0d exp 4", fifo_level); end
        checks++; if (bus.sample_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.sample_ready); end
        bus.sample_in    = 8'd60;
        bus.sample_valid = 1'b1;
        tick();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_hold_level got %0d exp 4", fifo_level); end
        k = 0;
        while (!bus.sample_ready && k < 600) begin tick(); k++; end
        checks++; if (k != 253) begin errors++; $display("FAIL full_ready_rise cycles got %0d exp 253", k); end
        tick();
        bus.sample_valid = 1'b0;
        first = pwm_out ? 1 : 0;
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_refill_level got %0d exp 4", fifo_level); end
        measure(255, h, u, l, m);
        checks++; if (h + first != 20) begin errors++; $display("FAIL full_duty20 got %0d exp 20", h + first); end
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL full_after_pop_level got %0d exp 3", fifo_level); end
        for (int p = 0; p < 4; p++) begin
            measure(256, h, u, l, m);
            checks++; if (h != exp_d[p]) begin errors++; $display("FAIL full_seq idx=%0d got %0d exp %0d", p, h, exp_d[p]); end
        end
    endtask

    task automatic test_reset_mid();
        int h, u, m; logic l;
        do_reset();
        push(8'd200); push(8'd200);
        tick();
        push(8'd30); push(8'd40);
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mid_level_pre got %0d exp 3", fifo_level); end
        repeat (5) tick();
        checks++; if (pwm_out !== 1'b1) begin errors++; $display("FAIL mid_pwm_pre got %b exp 1", pwm_out); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL mid_pwm got %b exp 0", pwm_out); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", fifo_level); end
        checks++; if (bus.sample_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", bus.sample_ready); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL mid_underrun got %b exp 0", underrun); end
        repeat (3) tick();
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL mid_prime_pwm got %b exp 0", pwm_out); end
        push(8'd77); push(8'd150);
        tick();
        measure(256, h, u, l, m);
        checks++; if (h != 77) begin errors++; $display("FAIL mid_restart_p1 got %0d exp 77", h); end
        measure(256, h, u, l, m);
        checks++; if (h != 150) begin errors++; $display("FAIL mid_restart_p2 got %0d exp 150", h); end
    endtask

    task automatic test_toggle();
        int vals [6] = '{11, 22, 33, 44, 55, 66};
        do_reset();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push(8'(vals[i]));
                    tick();
                end
            end
            begin
                int h, u, m, maxl;
                logic l;
                maxl = 0;
                repeat (4) tick();
                for (int p = 0; p < 6; p++) begin
                    measure(256, h, u, l, m);
                    if (m > maxl) maxl = m;
                    checks++; if (h != vals[p]) begin errors++; $display("FAIL tog_seq idx=%0d got %0d exp %0d", p, h, vals[p]); end
                    if (p < 5) begin
                        checks++; if (u != 0) begin errors++; $display("FAIL tog_underrun idx=%0d got %0d exp 0", p, u); end
                    end
                end
                checks++; if (maxl > 4) begin errors++; $display("FAIL tog_max_level got %0d exp <=4", maxl); end
            end
        join
    endtask

    initial begin
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        test_reset();
        test_basic();
        test_underrun();
        test_extremes();
        test_full_hold();
        test_reset_mid();
        test_toggle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
